seq_detector_n: RTL and testbench

Parametrised serial pattern detector, successor to the fixed three-ones detector. It watches a 1-bit serial stream qualified by a valid strobe and compares it against a runtime-programmable pattern of 1..PAT_W bits. It asserts a registered match flag and keeps a saturating match count. It sits between the serial front-end and the event logic. Out of reset it reproduces the legacy three-consecutive-ones behaviour.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_detector_n_sat_counter.sv | 22 ++
 rtl/seq_detector_n.sv | 89 ++++++++
 tb/tb_seq_detector_n.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int unsigned MAX_PAT_W = 64;
    localparam logic [MAX_PAT_W-1:0] RST_PATTERN = '1;
    localparam int unsigned RST_LEN = 3;

    function automatic int unsigned len_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_detector_n_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_detector_n.sv
// Serial pattern detector with runtime-programmable pattern/length, registered
// match pulse, saturating match count and optional overlapping detection.
module seq_detector_n
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned OVERLAP = 1,
    parameter int unsigned LEN_W   = len_width(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN_W-1:0] fill
);

    localparam logic [LEN_W-1:0] RST_LEN_V = LEN_W'(clamp_len(RST_LEN, PAT_W));

    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    // Only PAT_W-1 bits are stored: the oldest bit of a full window is never
    // compared after the next shift, so the shifted window is rebuilt from these.
    logic [PAT_W-2:0] history_q;
    logic [LEN_W-1:0] fill_q;
    logic             match_q;

    logic [PAT_W-1:0] history_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_next;
    logic [LEN_W-1:0] len_clamped;
    logic             hit;
    logic             cnt_inc;

    always_comb begin
        history_next = {history_q, in_bit};
        mask         = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len_q));
        end
        fill_next   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        hit         = (len_q != '0) && (fill_next >= len_q)
                      && (((history_next ^ pattern_q) & mask) == '0);
        len_clamped = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
        cnt_inc     = in_valid && !cfg_load && hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= RST_PATTERN[PAT_W-1:0];
            len_q     <= RST_LEN_V;
            history_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= len_clamped;
            history_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (in_valid) begin
            history_q <= history_next[PAT_W-2:0];
            match_q   <= hit;
            fill_q    <= (hit && (OVERLAP == 0)) ? '0 : fill_next;
        end else begin
            match_q   <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (match_cnt)
    );

    assign match = match_q;
    assign fill  = fill_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed bench: three detector variants (overlap, non-overlap, 2-bit counter)
// driven by a shared stimulus, checked against hand-computed values.
module tb_seq_detector_n;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cnt_clr;

    logic             a_match, b_match, c_match;
    logic [15:0]      a_cnt, b_cnt;
    logic [1:0]       c_cnt;
    logic [LEN_W-1:0] a_fill, b_fill, c_fill;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detector_n #(.PAT_W(PAT_W), .CNT_W(16), .OVERLAP(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .match(a_match), .match_cnt(a_cnt), .fill(a_fill)
    );

    seq_detector_n #(.PAT_W(PAT_W), .CNT_W(16), .OVERLAP(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .match(b_match), .match_cnt(b_cnt), .fill(b_fill)
    );

    seq_detector_n #(.PAT_W(PAT_W), .CNT_W(2), .OVERLAP(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .match(c_match), .match_cnt(c_cnt), .fill(c_fill)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one cycle of input, then return #1 after the sampling edge.
    task automatic send(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_load    = 1'b1;
        send(1'b1, 1'b1);
        cfg_load    = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    logic [4:0] v_bits;
    logic [4:0] v_amatch;
    logic [4:0] v_bmatch;
    logic [6:0] s_bits;
    logic [6:0] s_amatch;
    logic [6:0] s_bmatch;
    logic [7:0] p_bits;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_match", 32'(a_match), 0);
        check("rst_cnt", 32'(a_cnt), 0);
        check("rst_fill", 32'(a_fill), 0);
        rst = 1'b1;

        // Legacy "111" out of reset: bits 1,1,1,1,0 (first bit in MSB)
        v_bits   = 5'b11110;
        v_amatch = 5'b00110;
        v_bmatch = 5'b00100;
        for (int i = 4; i >= 0; i--) begin
            send(1'b1, v_bits[i]);
            check("legacy_a_match", 32'(a_match), 32'(v_amatch[i]));
            check("legacy_b_match", 32'(b_match), 32'(v_bmatch[i]));
        end
        check("legacy_a_fill", 32'(a_fill), 3);
        check("legacy_a_cnt", 32'(a_cnt), 2);
        check("legacy_b_cnt", 32'(b_cnt), 1);
        check("legacy_b_fill", 32'(b_fill), 2);
        check("legacy_c_cnt", 32'(c_cnt), 2);

        // Saturation: six ones give four matches; the 2-bit count stops at 3
        pulse_rst();
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
        check("sat_a_cnt", 32'(a_cnt), 4);
        check("sat_c_cnt", 32'(c_cnt), 3);
        check("sat_c_match", 32'(c_match), 1);

        // cnt_clr on a match cycle
        cnt_clr = 1'b1;
        send(1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("clr_a_match", 32'(a_match), 1);
        check("clr_a_cnt", 32'(a_cnt), 0);
        check("clr_c_cnt", 32'(c_cnt), 0);

        // Async reset mid-sequence, then a gapped sequence
        pulse_rst();
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        check("mid_fill_pre", 32'(a_fill), 2);
        rst = 1'b0;
        #1;
        check("mid_fill_rst", 32'(a_fill), 0);
        rst = 1'b1;
        send(1'b1, 1'b1);
        check("mid_match_after", 32'(a_match), 0);
        check("mid_fill_after", 32'(a_fill), 1);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        check("gap_idle1", 32'(a_match), 0);
        send(1'b0, 1'b0);
        check("gap_idle2", 32'(a_match), 0);
        check("gap_fill", 32'(a_fill), 2);
        send(1'b1, 1'b1);
        check("gap_match", 32'(a_match), 1);
        check("gap_cnt", 32'(a_cnt), 1);

        // Pattern 1011 len 4; the valid bit alongside cfg_load is dropped
        load_cfg(8'b0000_1011, 4'd4);
        check("cfg_fill", 32'(a_fill), 0);
        check("cfg_match", 32'(a_match), 0);
        check("cfg_cnt_kept", 32'(a_cnt), 1);
        s_bits   = 7'b1011011;
        s_amatch = 7'b0001001;
        s_bmatch = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            send(1'b1, s_bits[i]);
            check("p1011_a_match", 32'(a_match), 32'(s_amatch[i]));
            check("p1011_b_match", 32'(b_match), 32'(s_bmatch[i]));
        end
        check("p1011_a_cnt", 32'(a_cnt), 3);
        check("p1011_b_fill", 32'(b_fill), 3);

        // Length 0 disables detection even against an all-zero pattern
        load_cfg(8'h00, 4'd0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0);
            check("len0_match", 32'(a_match), 0);
            check("len0_fill", 32'(a_fill), 0);
        end

        // Length PAT_W+3 clamps to PAT_W: match on the eighth bit of A5
        load_cfg(8'hA5, 4'(PAT_W + 3));
        p_bits = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send(1'b1, p_bits[i]);
            check("clamp_match", 32'(a_match), (i == 0) ? 1 : 0);
            check("clamp_fill", 32'(a_fill), 32'(8 - i));
        end
        check("clamp_b_fill", 32'(b_fill), 0);

        in_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
